// File: rtl/rocc_cmd_queue.sv
// RoCC command queue: buffers CPU commands, throttles dispatch on outstanding responses.
// Optional perf counters are enabled by defining ROCC_CMD_QUEUE_PERF_EN.
module rocc_cmd_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUT_CNT_WIDTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_cmd_valid,
  output logic                     cpu_cmd_ready,
  input  logic [6:0]               cpu_cmd_funct,
  input  logic [4:0]               cpu_cmd_rs2,
  input  logic [4:0]               cpu_cmd_rs1,
  input  logic [4:0]               cpu_cmd_rd,
  input  logic [6:0]               cpu_cmd_opcode,
  input  logic [63:0]              cpu_cmd_rs1_data,
  input  logic [63:0]              cpu_cmd_rs2_data,
  output logic                     acc_cmd_valid,
  input  logic                     acc_cmd_ready,
  output logic [6:0]               acc_cmd_funct,
  output logic [4:0]               acc_cmd_rs2,
  output logic [4:0]               acc_cmd_rs1,
  output logic [4:0]               acc_cmd_rd,
  output logic [6:0]               acc_cmd_opcode,
  output logic [63:0]              acc_cmd_rs1_data,
  output logic [63:0]              acc_cmd_rs2_data,
  input  logic                     acc_resp_valid,
  input  logic                     cpu_resp_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     resp_err,
  output logic [31:0]              perf_stall_cycles,
  output logic [$clog2(DEPTH):0]   perf_max_occ
);

  localparam int AW      = $clog2(DEPTH);
  localparam int OW      = AW + 1;
  localparam int ENTRY_W = 157;
  localparam logic [OW-1:0]            FULL_OCC = OW'(DEPTH);
  localparam logic [OUT_CNT_WIDTH-1:0] MAX_OUT  = OUT_CNT_WIDTH'(MAX_OUTSTANDING);

  logic [ENTRY_W-1:0]       mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]            occ_q, occ_d;
  logic [OUT_CNT_WIDTH-1:0] out_q, out_d;
  logic                     resp_err_q, resp_err_d;
  logic                     primed_q;
  logic                     enq, deq, fire, nonempty;
  logic [ENTRY_W-1:0]       wr_entry, head_entry;

  // primed_q keeps cpu_cmd_ready low through reset without a combinational path from reset.
  assign nonempty      = (occ_q != '0);
  assign cpu_cmd_ready = primed_q & (occ_q < FULL_OCC);
  assign acc_cmd_valid = nonempty & (out_q < MAX_OUT);
  assign enq           = cpu_cmd_valid & cpu_cmd_ready;
  assign deq           = acc_cmd_valid & acc_cmd_ready;
  assign fire          = acc_resp_valid & cpu_resp_ready;

  assign wr_entry = {cpu_cmd_funct, cpu_cmd_rs2, cpu_cmd_rs1, cpu_cmd_rd,
                     cpu_cmd_opcode, cpu_cmd_rs1_data, cpu_cmd_rs2_data};
  assign head_entry = nonempty ? mem_q[rd_ptr_q] : '0;
  assign {acc_cmd_funct, acc_cmd_rs2, acc_cmd_rs1, acc_cmd_rd,
          acc_cmd_opcode, acc_cmd_rs1_data, acc_cmd_rs2_data} = head_entry;

  assign busy      = nonempty | (out_q != '0);
  assign occupancy = occ_q;
  assign resp_err  = resp_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    out_d      = out_q;
    resp_err_d = resp_err_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({enq, deq})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    // A response with nothing outstanding is flagged and never underflows the counter.
    if (deq && !fire)
      out_d = out_q + OUT_CNT_WIDTH'(1);
    else if (fire && !deq && (out_q != '0))
      out_d = out_q - OUT_CNT_WIDTH'(1);
    if (fire && (out_q == '0)) resp_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      out_q      <= '0;
      resp_err_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      resp_err_q <= resp_err_d;
      primed_q   <= 1'b1;
    end
  end

  // Payload storage carries no reset; the head is masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef ROCC_CMD_QUEUE_PERF_EN
  logic [31:0]   stall_q;
  logic [OW-1:0] max_occ_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      max_occ_q <= '0;
    end else begin
      if (cpu_cmd_valid && !cpu_cmd_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (occ_d > max_occ_q) max_occ_q <= occ_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_max_occ      = max_occ_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_max_occ      = '0;
`endif

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Scoreboard bench for rocc_cmd_queue: queue-based reference model plus negedge monitor.
module tb_rocc_cmd_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int CW    = 157;

  logic          clock;
  logic          reset;
  logic          cpu_cmd_valid, cpu_cmd_ready;
  logic [6:0]    cpu_cmd_funct, cpu_cmd_opcode;
  logic [4:0]    cpu_cmd_rs2, cpu_cmd_rs1, cpu_cmd_rd;
  logic [63:0]   cpu_cmd_rs1_data, cpu_cmd_rs2_data;
  logic          acc_cmd_valid, acc_cmd_ready;
  logic [6:0]    acc_cmd_funct, acc_cmd_opcode;
  logic [4:0]    acc_cmd_rs2, acc_cmd_rs1, acc_cmd_rd;
  logic [63:0]   acc_cmd_rs1_data, acc_cmd_rs2_data;
  logic          acc_resp_valid, cpu_resp_ready;
  logic          busy, resp_err;
  logic [OW-1:0] occupancy, perf_max_occ;
  logic [31:0]   perf_stall_cycles;

  rocc_cmd_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .OUT_CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_funct(cpu_cmd_funct), .cpu_cmd_rs2(cpu_cmd_rs2), .cpu_cmd_rs1(cpu_cmd_rs1),
    .cpu_cmd_rd(cpu_cmd_rd), .cpu_cmd_opcode(cpu_cmd_opcode),
    .cpu_cmd_rs1_data(cpu_cmd_rs1_data), .cpu_cmd_rs2_data(cpu_cmd_rs2_data),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rs2(acc_cmd_rs2), .acc_cmd_rs1(acc_cmd_rs1),
    .acc_cmd_rd(acc_cmd_rd), .acc_cmd_opcode(acc_cmd_opcode),
    .acc_cmd_rs1_data(acc_cmd_rs1_data), .acc_cmd_rs2_data(acc_cmd_rs2_data),
    .acc_resp_valid(acc_resp_valid), .cpu_resp_ready(cpu_resp_ready),
    .busy(busy), .occupancy(occupancy), .resp_err(resp_err),
    .perf_stall_cycles(perf_stall_cycles), .perf_max_occ(perf_max_occ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model: pending commands in order, plus scalar bookkeeping.
  logic [CW-1:0] exp_q[$];
  int            m_out;
  bit            m_err, m_primed;
  longint        m_stall;
  int            m_max;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] acc_payload();
    return {acc_cmd_funct, acc_cmd_rs2, acc_cmd_rs1, acc_cmd_rd,
            acc_cmd_opcode, acc_cmd_rs1_data, acc_cmd_rs2_data};
  endfunction

  function automatic logic [CW-1:0] exp_stall();
`ifdef ROCC_CMD_QUEUE_PERF_EN
    return CW'(m_stall > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_stall);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_max();
`ifdef ROCC_CMD_QUEUE_PERF_EN
    return CW'(m_max);
`else
    return '0;
`endif
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_out = 0; m_err = 0; m_primed = 0; m_stall = 0; m_max = 0;
    end else begin
      bit can_take, enq, deq, fire;
      can_take = m_primed && (exp_q.size() < DEPTH);
      enq  = cpu_cmd_valid && can_take;
      deq  = (exp_q.size() != 0) && (m_out < MAXO) && acc_cmd_ready;
      fire = acc_resp_valid && cpu_resp_ready;
      if (cpu_cmd_valid && !can_take) m_stall++;
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back({cpu_cmd_funct, cpu_cmd_rs2, cpu_cmd_rs1, cpu_cmd_rd,
                                cpu_cmd_opcode, cpu_cmd_rs1_data, cpu_cmd_rs2_data});
      if (fire && m_out == 0) m_err = 1;
      m_out = m_out + (deq ? 1 : 0) - ((fire && (m_out > 0 || deq)) ? 1 : 0);
      if (exp_q.size() > m_max) m_max = exp_q.size();
      m_primed = 1;
    end
  end

  // Monitor: compares every observable output against the model away from the clock edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_outputs", CW'({cpu_cmd_ready, acc_cmd_valid, busy, occupancy, resp_err}), '0);
      check("rst_perf", CW'({perf_stall_cycles, perf_max_occ}), '0);
      check("rst_payload", acc_payload(), '0);
    end else begin
      check("occupancy", CW'(occupancy), CW'(exp_q.size()));
      check("cpu_cmd_ready", CW'(cpu_cmd_ready), CW'(m_primed && exp_q.size() < DEPTH));
      check("acc_cmd_valid", CW'(acc_cmd_valid), CW'(exp_q.size() != 0 && m_out < MAXO));
      check("busy", CW'(busy), CW'(exp_q.size() != 0 || m_out != 0));
      check("resp_err", CW'(resp_err), CW'(m_err));
      check("perf_stall", CW'(perf_stall_cycles), exp_stall());
      check("perf_max_occ", CW'(perf_max_occ), exp_max());
      if (exp_q.size() != 0) check("payload", acc_payload(), exp_q[0]);
      else check("payload_empty", acc_payload(), '0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cmd(input logic [CW-1:0] c);
    {cpu_cmd_funct, cpu_cmd_rs2, cpu_cmd_rs1, cpu_cmd_rd,
     cpu_cmd_opcode, cpu_cmd_rs1_data, cpu_cmd_rs2_data} = c;
  endtask

  function automatic logic [CW-1:0] rand_cmd();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[CW-1:0];
  endfunction

  task automatic set_resp(input logic v);
    acc_resp_valid = v;
    cpu_resp_ready = v;
  endtask

  initial begin
    reset = 1'b0;
    cpu_cmd_valid = 0; acc_cmd_ready = 0; set_resp(0);
    drive_cmd('0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Idle after reset
    repeat (5) step();
    check("idle_ready", CW'(cpu_cmd_ready), CW'(1));
    check("idle_valid", CW'(acc_cmd_valid), CW'(0));
    check("idle_busy", CW'(busy), CW'(0));
    check("idle_occ", CW'(occupancy), CW'(0));

    // Single command through, then one response
    acc_cmd_ready = 1;
    drive_cmd('0);
    cpu_cmd_funct = 7'h05; cpu_cmd_rd = 5'd3; cpu_cmd_rs1_data = 64'h1234;
    cpu_cmd_valid = 1;
    step();
    cpu_cmd_valid = 0;
    check("one_valid", CW'(acc_cmd_valid), CW'(1));
    check("one_funct", CW'(acc_cmd_funct), CW'(7'h05));
    check("one_rd", CW'(acc_cmd_rd), CW'(5'd3));
    check("one_rs1_data", CW'(acc_cmd_rs1_data), CW'(64'h1234));
    step();
    check("one_busy_out", CW'(busy), CW'(1));
    step();
    check("one_busy_hold", CW'(busy), CW'(1));
    set_resp(1);
    step();
    set_resp(0);
    check("one_busy_done", CW'(busy), CW'(0));

    // Fill to DEPTH with dispatch blocked, then stall the 5th for 3 cycles
    acc_cmd_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cmd(rand_cmd());
      cpu_cmd_valid = 1;
      step();
    end
    check("full_occ", CW'(occupancy), CW'(4));
    check("full_ready", CW'(cpu_cmd_ready), CW'(0));
    drive_cmd(rand_cmd());
    repeat (3) step();
    cpu_cmd_valid = 0;
`ifdef ROCC_CMD_QUEUE_PERF_EN
    check("stall_3", CW'(perf_stall_cycles), CW'(3));
    check("max_occ_4", CW'(perf_max_occ), CW'(4));
`endif

    // Throttle at MAX_OUTSTANDING, one response releases the next dispatch
    acc_cmd_ready = 1;
    repeat (3) step();
    check("throttle_valid", CW'(acc_cmd_valid), CW'(0));
    check("throttle_occ", CW'(occupancy), CW'(2));
    set_resp(1);
    step();
    set_resp(0);
    check("resume_valid", CW'(acc_cmd_valid), CW'(1));
    step();
    check("resume_occ", CW'(occupancy), CW'(1));
    set_resp(1);
    repeat (3) step();
    set_resp(0);
    check("drained_busy", CW'(busy), CW'(0));
    check("drained_err", CW'(resp_err), CW'(0));

    // Spurious response sets a sticky error
    set_resp(1);
    step();
    set_resp(0);
    check("err_set", CW'(resp_err), CW'(1));
    check("err_busy", CW'(busy), CW'(0));
    repeat (3) step();
    check("err_sticky", CW'(resp_err), CW'(1));

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      drive_cmd(rand_cmd());
      cpu_cmd_valid = ($urandom_range(0, 99) < 60);
      acc_cmd_ready = ($urandom_range(0, 99) < 55);
      set_resp($urandom_range(0, 99) < 35);
      step();
    end
    cpu_cmd_valid = 0; acc_cmd_ready = 0; set_resp(0);

    // Clean reset, then 3 queued / 2 outstanding and a mid-cycle reset
    reset = 0;
    step();
    reset = 1;
    step();
    check("rst_clears_err", CW'(resp_err), CW'(0));
    acc_cmd_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(rand_cmd());
      cpu_cmd_valid = 1;
      step();
    end
    cpu_cmd_valid = 0;
    check("pre_rst_occ", CW'(occupancy), CW'(3));
    check("pre_rst_valid", CW'(acc_cmd_valid), CW'(0));
    #1 reset = 0;
    #1;
    check("async_rst_outs", CW'({cpu_cmd_ready, acc_cmd_valid, busy, occupancy, resp_err}), '0);
    check("async_rst_payload", acc_payload(), '0);
    repeat (2) step();
    reset = 1;
    repeat (3) step();
    check("post_rst_busy", CW'(busy), CW'(0));
    check("post_rst_occ", CW'(occupancy), CW'(0));
    check("post_rst_valid", CW'(acc_cmd_valid), CW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
